data_mem_io_unit: RTL

Word-addressed data memory plus memory-mapped I/O that sits directly downstream of the load/store lane-alignment stage in the MEM stage. It consumes the lane-shifted store word and byte-write enables and stores them into a byte-enabled synchronous RAM or an MMIO register. It returns the raw 32-bit word that the alignment stage then extracts and sign-extends. MMIO provides a UART TX FIFO with a valid/ready handshake, a FIFO status register and a free-running cycle counter; the block stalls the pipeline when a UART store finds the FIFO full.

---
 rtl/dmem_io_pkg.sv | 54 +++++
 rtl/data_mem_io_unit_fifo.sv | 46 ++++
 rtl/data_mem_io_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_io_pkg.sv
// Shared constants, status-register layout and address-region decode
// for the MEM-stage data memory / MMIO block.
package dmem_io_pkg;

  localparam int unsigned MEM_WORDS_DEF      = 30720;
  localparam logic [16:0] UART_TX_ADDR_DEF   = 17'h1F000;
  localparam logic [16:0] UART_STAT_ADDR_DEF = 17'h1F004;
  localparam logic [16:0] CYCLE_ADDR_DEF     = 17'h1F008;

  // Status register layout: {20'd0, count[3:0], 6'd0, empty, full}
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_W     = 4;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_UART_TX,
    RGN_UART_STAT,
    RGN_CYCLE,
    RGN_NONE
  } region_e;

  // Decode on the word-aligned address; the low two bits never matter.
  function automatic region_e decode_region(
    input logic [16:0] addr,
    input int unsigned mem_words,
    input logic [16:0] tx_a,
    input logic [16:0] stat_a,
    input logic [16:0] cyc_a
  );
    logic [16:0] w_word;
    w_word = {addr[16:2], 2'b00};
    if ({17'd0, addr[16:2]} < mem_words) return RGN_RAM;
    if (w_word == tx_a)                  return RGN_UART_TX;
    if (w_word == stat_a)                return RGN_UART_STAT;
    if (w_word == cyc_a)                 return RGN_CYCLE;
    return RGN_NONE;
  endfunction

  function automatic logic [31:0] stat_word(
    input logic [STAT_CNT_W-1:0] cnt,
    input logic                  empty,
    input logic                  full
  );
    logic [31:0] s;
    s = '0;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    s[STAT_EMPTY_BIT]             = empty;
    s[STAT_FULL_BIT]              = full;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_io_unit_fifo.sv
// Pointer-based synchronous FIFO; the extra pointer MSB separates
// full from empty when the index bits are equal.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_push_ok, w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage and pointers; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_io_unit.sv
// MEM-stage data RAM plus MMIO (UART TX FIFO, FIFO status, cycle counter).
// Takes the lane-shifted store word / byte enables and returns the raw word.
module data_mem_io_unit
  import dmem_io_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = MEM_WORDS_DEF,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [16:0] UART_TX_ADDR   = UART_TX_ADDR_DEF,
  parameter logic [16:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter logic [16:0] CYCLE_ADDR     = CYCLE_ADDR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_re,
  input  logic [16:0] i_r_addr,
  input  logic [16:0] i_w_addr,
  input  logic [31:0] i_w_data,
  input  logic [3:0]  i_we,
  output logic [31:0] o_r_data,
  output logic        o_stall,
  output logic [7:0]  o_uart_tx_data,
  output logic        o_uart_tx_valid,
  input  logic        i_uart_tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(MEM_WORDS);

  region_e       w_wr_rgn, w_rd_rgn;
  logic          w_full, w_empty;
  logic [CW-1:0] w_cnt;
  logic          w_uart_st, w_push, w_pop;
  logic          w_rd_en, w_ram_we, w_ram_re;
  logic [31:0]   w_stat;
  logic [AW-1:0] w_widx, w_ridx;

  logic [31:0]   r_ram [MEM_WORDS];
  logic [31:0]   r_ram_q;
  logic [31:0]   r_mmio_q;
  logic [31:0]   r_cycle;
  logic          r_src_ram;

  assign w_wr_rgn = decode_region(i_w_addr, MEM_WORDS, UART_TX_ADDR, UART_STAT_ADDR, CYCLE_ADDR);
  assign w_rd_rgn = decode_region(i_r_addr, MEM_WORDS, UART_TX_ADDR, UART_STAT_ADDR, CYCLE_ADDR);
  assign w_widx   = i_w_addr[AW+1:2];
  assign w_ridx   = i_r_addr[AW+1:2];

  // Stall depends on full only, so a same-cycle pop cannot release it;
  // the held store is re-presented and pushes once space exists.
  assign w_uart_st = (|i_we) && (w_wr_rgn == RGN_UART_TX);
  assign o_stall   = w_uart_st && w_full;
  assign w_push    = w_uart_st && !w_full;
  assign w_pop     = o_uart_tx_valid && i_uart_tx_ready;

  // A load presented during a stall is re-presented later, so ignore it now.
  assign w_rd_en  = i_re && !o_stall;
  assign w_ram_re = w_rd_en && (w_rd_rgn == RGN_RAM);
  assign w_ram_we = (|i_we) && (w_wr_rgn == RGN_RAM);

  assign w_stat          = stat_word(STAT_CNT_W'(w_cnt), w_empty, w_full);
  assign o_uart_tx_valid = !w_empty;
  assign o_r_data        = r_src_ram ? r_ram_q : r_mmio_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (i_w_data[7:0]),
    .i_pop   (w_pop),
    .o_data  (o_uart_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  // Byte-enabled RAM with read-first port; no reset so it maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (i_we[k]) r_ram[w_widx][8*k +: 8] <= i_w_data[8*k +: 8];
      end
    end
    if (w_ram_re) r_ram_q <= r_ram[w_ridx];
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cycle <= '0;
    else          r_cycle <= r_cycle + 32'd1;
  end

  // Capture read source and MMIO value in the load cycle; hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src_ram <= 1'b0;
      r_mmio_q  <= '0;
    end else if (w_rd_en) begin
      r_src_ram <= (w_rd_rgn == RGN_RAM);
      case (w_rd_rgn)
        RGN_UART_STAT: r_mmio_q <= w_stat;
        RGN_CYCLE:     r_mmio_q <= r_cycle;
        default:       r_mmio_q <= '0;
      endcase
    end
  end

endmodule
